// File: rtl/vending_controller.sv
// Coin vending controller: credit accumulation, single-product vend, dime/nickel change.
// Build option: define CHANGE_RETURN_EN to enable change return and cancel refunds.
module vending_controller #(
  parameter int PRICE    = 7,
  parameter int CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                product,
  output logic                change_nickel,
  output logic                change_dime,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] V1      = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] V2      = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] V5      = CREDIT_W'(5);

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  reject_q, reject_d;
  logic                  any_coin, coin_ok;
  logic [CREDIT_W-1:0]   coin_val, sum;

`ifdef CHANGE_RETURN_EN
  logic [CREDIT_W-1:0]   excess_q, excess_d;
`else
  logic                  unused_cancel;
  assign unused_cancel = cancel;
`endif

  // Exactly one coin line high is a valid insertion
  assign any_coin = nickel | dime | quarter;
  assign coin_ok  = (nickel ^ dime ^ quarter) & ~(nickel & dime & quarter);
  assign coin_val = nickel ? V1 : (dime ? V2 : V5);
  assign sum      = credit_q + coin_val;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      reject_q <= 1'b0;
`ifdef CHANGE_RETURN_EN
      excess_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
`ifdef CHANGE_RETURN_EN
      excess_q <= excess_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
`ifdef CHANGE_RETURN_EN
    excess_d = excess_q;
`endif
    unique case (state_q)
      COLLECT: begin
`ifdef CHANGE_RETURN_EN
        if (cancel) begin
          reject_d = any_coin;
          if (credit_q != '0) begin
            excess_d = credit_q;
            credit_d = '0;
            state_d  = CHANGE;
          end
        end else
`endif
        if (any_coin) begin
          if (!coin_ok) begin
            reject_d = 1'b1;
          end else if (sum < PRICE_C) begin
            credit_d = sum;
          end else begin
`ifdef CHANGE_RETURN_EN
            excess_d = sum - PRICE_C;
`endif
            credit_d = '0;
            state_d  = VEND;
          end
        end
      end
      VEND: begin
        reject_d = any_coin;
`ifdef CHANGE_RETURN_EN
        state_d  = (excess_q != '0) ? CHANGE : COLLECT;
`else
        state_d  = COLLECT;
`endif
      end
`ifdef CHANGE_RETURN_EN
      CHANGE: begin
        reject_d = any_coin;
        if (excess_q >= V2) excess_d = excess_q - V2;
        else                excess_d = excess_q - V1;
        if (excess_d == '0) state_d = COLLECT;
      end
`endif
      default: state_d = COLLECT;
    endcase
  end

  assign product     = (state_q == VEND);
  assign busy        = (state_q != COLLECT);
  assign credit      = credit_q;
  assign coin_reject = reject_q;

`ifdef CHANGE_RETURN_EN
  assign change_dime   = (state_q == CHANGE) && (excess_q >= V2);
  assign change_nickel = (state_q == CHANGE) && (excess_q < V2);
`else
  assign change_dime   = 1'b0;
  assign change_nickel = 1'b0;
`endif

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller at PRICE=7, CREDIT_W=4.
// Expectations follow the CHANGE_RETURN_EN setting of the build.
module tb_vending_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
  logic       product, change_nickel, change_dime, coin_reject, busy;
  logic [3:0] credit;

  int n_checks = 0;
  int n_fail   = 0;

  vending_controller #(.PRICE(7), .CREDIT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .nickel       (nickel),
    .dime         (dime),
    .quarter      (quarter),
    .cancel       (cancel),
    .product      (product),
    .change_nickel(change_nickel),
    .change_dime  (change_dime),
    .coin_reject  (coin_reject),
    .busy         (busy),
    .credit       (credit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as {product, dime, nickel, busy, reject, credit}
  task automatic expo(input string tag, input logic p, input logic cd,
                      input logic cn, input logic b, input logic r,
                      input logic [3:0] cr);
    check(tag, {7'd0, product, change_dime, change_nickel, busy,
                coin_reject, credit},
               {7'd0, p, cd, cn, b, r, cr});
  endtask

  task automatic cyc(input logic n, input logic d, input logic q,
                     input logic c);
    nickel = n; dime = d; quarter = q; cancel = c;
    @(posedge clock);
    #1;
    nickel = 0; dime = 0; quarter = 0; cancel = 0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 expo("reset", 0, 0, 0, 0, 0, 4'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    expo("reset_rel", 0, 0, 0, 0, 0, 4'd0);

    // nickel, dime, quarter -> 1, 3, vend with excess 1
    cyc(1, 0, 0, 0); expo("n_cr1", 0, 0, 0, 0, 0, 4'd1);
    cyc(0, 1, 0, 0); expo("d_cr3", 0, 0, 0, 0, 0, 4'd3);
    cyc(0, 0, 1, 0); expo("q_vend", 1, 0, 0, 1, 0, 4'd0);
`ifdef CHANGE_RETURN_EN
    cyc(0, 0, 0, 0); expo("chg_n1", 0, 0, 1, 1, 0, 4'd0);
`endif
    cyc(0, 0, 0, 0); expo("idle1", 0, 0, 0, 0, 0, 4'd0);

    // quarter, quarter -> vend with excess 3
    cyc(0, 0, 1, 0); expo("qq_cr5", 0, 0, 0, 0, 0, 4'd5);
    cyc(0, 0, 1, 0); expo("qq_vend", 1, 0, 0, 1, 0, 4'd0);
`ifdef CHANGE_RETURN_EN
    cyc(0, 0, 0, 0); expo("qq_dime", 0, 1, 0, 1, 0, 4'd0);
    cyc(0, 0, 0, 0); expo("qq_nick", 0, 0, 1, 1, 0, 4'd0);
`endif
    cyc(0, 0, 0, 0); expo("qq_idle", 0, 0, 0, 0, 0, 4'd0);

    // exact price: busy for one cycle, then back-to-back coin accepted
    cyc(0, 1, 0, 0); expo("ex_cr2", 0, 0, 0, 0, 0, 4'd2);
    cyc(0, 0, 1, 0); expo("ex_vend", 1, 0, 0, 1, 0, 4'd0);
    cyc(0, 0, 0, 0); expo("ex_idle", 0, 0, 0, 0, 0, 4'd0);
    cyc(0, 0, 1, 0); expo("b2b_cr5", 0, 0, 0, 0, 0, 4'd5);
    cyc(0, 1, 0, 0); expo("b2b_vend", 1, 0, 0, 1, 0, 4'd0);

    // quarter while vending is rejected
    cyc(0, 0, 1, 0); expo("busy_rej", 0, 0, 0, 0, 1, 4'd0);
    cyc(0, 0, 0, 0); expo("busy_rej0", 0, 0, 0, 0, 0, 4'd0);

    // multi-coin pulses are rejected
    cyc(1, 1, 0, 0); expo("nd_rej", 0, 0, 0, 0, 1, 4'd0);
    cyc(0, 0, 0, 0); expo("nd_rej0", 0, 0, 0, 0, 0, 4'd0);
    cyc(1, 1, 1, 0); expo("ndq_rej", 0, 0, 0, 0, 1, 4'd0);
    cyc(0, 0, 0, 0); expo("ndq_rej0", 0, 0, 0, 0, 0, 4'd0);

    // cancel at credit 0, then cancel at credit 3
    cyc(0, 0, 0, 1); expo("can0", 0, 0, 0, 0, 0, 4'd0);
    cyc(1, 0, 0, 0); expo("c_cr1", 0, 0, 0, 0, 0, 4'd1);
    cyc(0, 1, 0, 0); expo("c_cr3", 0, 0, 0, 0, 0, 4'd3);
`ifdef CHANGE_RETURN_EN
    cyc(0, 0, 0, 1); expo("can_dime", 0, 1, 0, 1, 0, 4'd0);
    cyc(0, 0, 0, 0); expo("can_nick", 0, 0, 1, 1, 0, 4'd0);
    cyc(0, 0, 0, 0); expo("can_idle", 0, 0, 0, 0, 0, 4'd0);
    // cancel beats a simultaneous coin
    cyc(1, 0, 0, 0); expo("cc_cr1", 0, 0, 0, 0, 0, 4'd1);
    cyc(0, 1, 0, 1); expo("cc_nick", 0, 0, 1, 1, 1, 4'd0);
    cyc(0, 0, 0, 0); expo("cc_idle", 0, 0, 0, 0, 0, 4'd0);
`else
    cyc(0, 0, 0, 1); expo("can_keep", 0, 0, 0, 0, 0, 4'd3);
    cyc(0, 1, 0, 1); expo("can_coin", 0, 0, 0, 0, 0, 4'd5);
    cyc(0, 0, 1, 0); expo("can_vend", 1, 0, 0, 1, 0, 4'd0);
    cyc(0, 0, 0, 0); expo("can_idle", 0, 0, 0, 0, 0, 4'd0);
`endif

    // reset mid-transaction forfeits remaining change
    cyc(0, 0, 1, 0); expo("rs_cr5", 0, 0, 0, 0, 0, 4'd5);
    cyc(0, 0, 1, 0); expo("rs_vend", 1, 0, 0, 1, 0, 4'd0);
`ifdef CHANGE_RETURN_EN
    cyc(0, 0, 0, 0); expo("rs_dime", 0, 1, 0, 1, 0, 4'd0);
`endif
    reset = 1'b1;
    #1 expo("rs_async", 0, 0, 0, 0, 0, 4'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    cyc(0, 0, 0, 0); expo("rs_after1", 0, 0, 0, 0, 0, 4'd0);
    cyc(0, 0, 0, 0); expo("rs_after2", 0, 0, 0, 0, 0, 4'd0);
    cyc(0, 1, 0, 0); expo("rs_coin", 0, 0, 0, 0, 0, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
